// File: rtl/tdc_pkg.sv
// Shared constants and state encoding for the TDC result UART transmitter.
package tdc_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. A start request sampled at the end of the
// stop bit chains the next byte with no idle gap.
module uart_tx_byte
    import tdc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       byte_done,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e   state_reg;
    logic [CW-1:0] baud_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        tx_reg;
    logic        baud_wrap;

    assign baud_wrap = (baud_cnt_reg == CW'(CLKS_PER_BIT - 1));
    assign ready     = (state_reg == IDLE);
    assign byte_done = (state_reg == STOP) && baud_wrap;
    assign tx        = tx_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= START;
                        shift_reg    <= data;
                        baud_cnt_reg <= '0;
                        tx_reg       <= 1'b0;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        state_reg    <= DATA;
                        bit_idx_reg  <= '0;
                        baud_cnt_reg <= '0;
                        tx_reg       <= shift_reg[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        baud_cnt_reg <= '0;
                        // Back-to-back bytes go straight into the next start bit
                        if (start) begin
                            state_reg <= START;
                            shift_reg <= data;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/tdc_result_tx.sv
// Sends each accepted TDC measurement as a SYNC / DATA / CHK frame over UART,
// with CHK = SYNC ^ DATA.
module tdc_result_tx
    import tdc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_STAGES   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  meas_valid,
    input  logic [NUM_STAGES-1:0] meas_data,
    output logic                  meas_ready,
    output logic                  tx,
    output logic                  busy
);

    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
        $error("tdc_result_tx: NUM_STAGES must be 1..8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("tdc_result_tx: CLKS_PER_BIT must be >= 2");
    end

    logic [7:0] meas_byte;
    logic [7:0] data_byte_reg;
    logic [7:0] chk_reg;
    logic [1:0] byte_idx_reg;
    logic       busy_reg;
    logic       byte_ready;
    logic       byte_done;
    logic       byte_start;
    logic [7:0] byte_data;
    logic       accept;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_zext
            if (gi < NUM_STAGES) begin : g_bit
                assign meas_byte[gi] = meas_data[gi];
            end else begin : g_zero
                assign meas_byte[gi] = 1'b0;
            end
        end
    endgenerate

    assign meas_ready = byte_ready;
    assign busy       = busy_reg;
    assign accept     = meas_valid && byte_ready;

    // While idle the serializer is offered the sync byte; mid-frame it is
    // offered the byte that follows the one currently in its stop bit.
    assign byte_start = byte_ready ? meas_valid
                                   : (byte_idx_reg < 2'(FRAME_BYTES - 1));
    assign byte_data  = byte_ready ? SYNC_BYTE
                      : (byte_idx_reg == 2'd0) ? data_byte_reg : chk_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_byte_reg <= '0;
            chk_reg       <= '0;
            byte_idx_reg  <= '0;
            busy_reg      <= 1'b0;
        end else if (accept) begin
            data_byte_reg <= meas_byte;
            chk_reg       <= SYNC_BYTE ^ meas_byte;
            byte_idx_reg  <= '0;
            busy_reg      <= 1'b1;
        end else if (byte_done) begin
            if (byte_idx_reg < 2'(FRAME_BYTES - 1)) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
            end else begin
                busy_reg <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .reset     (reset),
        .start     (byte_start),
        .data      (byte_data),
        .ready     (byte_ready),
        .byte_done (byte_done),
        .tx        (tx)
    );

endmodule

// File: tb/tb_tdc_result_tx.sv
// Directed frame vectors for tdc_result_tx with a per-cycle UART waveform check.
module tb_tdc_result_tx;

    localparam int CPB       = 4;
    localparam int NS        = 5;
    localparam int FRAME_CYC = 30 * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          meas_valid = 1'b0;
    logic [NS-1:0] meas_data = '0;
    logic          meas_ready;
    logic          tx;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic samples [FRAME_CYC];

    typedef struct {
        logic [NS-1:0] data;
        bit            hold;
        bit            disturb;
        logic [7:0]    exp_b1;
        logic [7:0]    exp_chk;
    } vec_t;

    vec_t vecs [5];

    tdc_result_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_STAGES  (NS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .meas_valid (meas_valid),
        .meas_data  (meas_data),
        .meas_ready (meas_ready),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge. Accepts d on the next posedge, records the
    // 120 frame cycles and checks them against the hand-computed bytes.
    task automatic run_frame(input logic [NS-1:0] d, input bit hold, input bit disturb,
                             input logic [7:0] exp_b1, input logic [7:0] exp_chk);
        logic [7:0] exp_bytes [3];
        logic [7:0] dec [3];
        int busy_bad;
        int rdy_bad;
        int wave_bad;
        logic lvl;
        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = exp_b1;
        exp_bytes[2] = exp_chk;
        busy_bad = 0;
        rdy_bad  = 0;
        wave_bad = 0;
        check("ready_pre", int'(meas_ready), 1);
        meas_data  = d;
        meas_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            if (!hold && i == 0) meas_valid = 1'b0;
            if (disturb && i == 50) begin
                meas_data  = ~d;
                meas_valid = 1'b1;
            end
            if (disturb && i == 53) meas_valid = 1'b0;
            samples[i] = tx;
            if (busy !== 1'b1) busy_bad++;
            if (meas_ready !== 1'b0) rdy_bad++;
        end
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 10; j++) begin
                lvl = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_bytes[b][j-1];
                for (int c = 0; c < CPB; c++)
                    if (samples[b*10*CPB + j*CPB + c] !== lvl) wave_bad++;
            end
            for (int j = 0; j < 8; j++)
                dec[b][j] = samples[b*10*CPB + (j+1)*CPB + CPB/2];
        end
        check("byte0_sync", int'(dec[0]), int'(exp_bytes[0]));
        check("byte1_data", int'(dec[1]), int'(exp_bytes[1]));
        check("byte2_chk", int'(dec[2]), int'(exp_bytes[2]));
        check("monitor_chk", int'(dec[2]), int'(8'hA5 ^ dec[1]));
        check("wave_errors", wave_bad, 0);
        check("busy_low_cycles", busy_bad, 0);
        check("ready_high_cycles", rdy_bad, 0);
        @(negedge clk);
        check("end_tx", int'(tx), 1);
        check("end_busy", int'(busy), 0);
        check("end_ready", int'(meas_ready), 1);
        $display("frame data=0x%02h -> %02h %02h %02h", d, dec[0], dec[1], dec[2]);
    endtask

    initial begin
        vecs[0] = '{data: 5'h16, hold: 1'b0, disturb: 1'b0, exp_b1: 8'h16, exp_chk: 8'hB3};
        vecs[1] = '{data: 5'h00, hold: 1'b0, disturb: 1'b1, exp_b1: 8'h00, exp_chk: 8'hA5};
        vecs[2] = '{data: 5'h1F, hold: 1'b1, disturb: 1'b0, exp_b1: 8'h1F, exp_chk: 8'hBA};
        vecs[3] = '{data: 5'h03, hold: 1'b0, disturb: 1'b0, exp_b1: 8'h03, exp_chk: 8'hA6};
        vecs[4] = '{data: 5'h15, hold: 1'b0, disturb: 1'b0, exp_b1: 8'h15, exp_chk: 8'hB0};

        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(meas_ready), 1);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", int'(meas_ready), 1);

        // Row 2 holds meas_valid, so row 3 is accepted in the single idle cycle.
        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].data, vecs[v].hold, vecs[v].disturb,
                      vecs[v].exp_b1, vecs[v].exp_chk);

        // Reset during bit 3 of the data byte, then a fresh frame.
        @(negedge clk);
        meas_data  = 5'h16;
        meas_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 57; i++) begin
            @(negedge clk);
            meas_valid = 1'b0;
        end
        check("pre_reset_tx_bit3", int'(tx), 0);
        check("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_tx", int'(tx), 1);
        check("midreset_busy", int'(busy), 0);
        check("midreset_ready", int'(meas_ready), 1);
        reset = 1'b0;
        @(negedge clk);
        run_frame(5'h0A, 1'b0, 1'b0, 8'h0A, 8'hAF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_result_tx.md
Name: tdc_result_tx

Overview:
UART transmitter that sends TDC stage-delay measurements from the fabric to the host, in the opposite direction to the TDC's incoming UART data path. Each accepted measurement becomes a 3-byte frame: sync, data, checksum. Each byte is sent 8N1, LSB first, on a single tx line. Sits between the TDC capture logic (upstream, valid/ready) and the board UART TX pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2
NUM_STAGES, 5, width of the measurement word; legal range 1..8, elaboration error otherwise

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
meas_valid  input  1  upstream has a measurement on meas_data
meas_data  input  NUM_STAGES  stage-delay measurement word
meas_ready  output  1  block can accept a measurement this cycle
tx  output  1  UART serial out, idle high
busy  output  1  frame in progress

Behaviour:
- Reset values: tx=1, busy=0, meas_ready=1, FSM=IDLE, all counters 0.
- Reset is synchronous and takes priority over every other event.
- meas_ready = (state==IDLE). It is combinational from state and does not depend on meas_valid.
- Accept condition: meas_valid && meas_ready at a rising edge.
  - On accept, capture meas_data zero-extended to 8 bits as DATA_BYTE.
  - Compute CHK = 0xA5 ^ DATA_BYTE.
  - Set byte index to 0 and enter START.
  - busy goes to 1 on the same edge.
- Frame byte order: byte 0 = SYNC 0xA5, byte 1 = DATA_BYTE, byte 2 = CHK.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1. Accept -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte index < 2: increment the index, load the next byte, go to START. If byte index = 2: go to IDLE and set busy=0.
- Latency and timing:
  - Accept at edge k: tx=0 from cycle k+1 through k+CLKS_PER_BIT.
  - No idle gap between the 3 bytes of a frame.
  - Frame duration = 30*CLKS_PER_BIT cycles.
  - Minimum spacing between frames is one IDLE cycle (tx=1). With meas_valid held high, the next accept happens in that IDLE cycle.
- Baud counter runs 0..CLKS_PER_BIT-1. Its wrap marks the bit boundary. It resets to 0 on every state entry.
- meas_data and meas_valid are ignored while busy; the captured word is held stable until frame end.
- Dropping meas_valid after accept has no effect on the frame.
- Reset mid-frame: on the next edge tx=1, busy=0, ready=1. The frame is abandoned with no partial resume.
- tx is driven from a flop, so there are no combinational glitches on the pin.

Decomposition:
- Package tdc_pkg holds:
  - SYNC_BYTE = 8'hA5
  - FRAME_BYTES = 3
  - the state enum tx_state_e {IDLE, START, DATA, STOP}
- Sub-module uart_tx_byte: a byte serializer with start/ready/tx, parameterized by CLKS_PER_BIT, containing START/DATA/STOP and the baud counter.
- tdc_result_tx wraps uart_tx_byte with the valid/ready handshake, byte sequencing and checksum.

Test Plan:
- CLKS_PER_BIT=4, accept meas_data=5'b10110 at edge k -> tx decodes to bytes A5, 16, B3. tx low for cycles k+1..k+4. busy=1 for 120 cycles. meas_ready back to 1 at cycle k+121.
- meas_data=0 -> frame A5, 00, A5. Stop bits are high for exactly 4 cycles each. No gaps between bytes.
- meas_valid held high with data 5'h1F then 5'h03 -> two frames, (A5, 1F, BA) then (A5, 03, A6), separated by exactly one idle-high cycle.
- Change meas_data and pulse meas_valid during a frame -> meas_ready=0, and the in-flight frame bytes are unchanged.
- Assert reset during the DATA byte bit 3 -> next cycle tx=1, busy=0, meas_ready=1. A fresh accept then produces a complete, correct frame.
- Checker: a bit-accurate UART monitor samples mid-bit. It flags any frame where CHK != 0xA5 ^ DATA, and any start bit whose length != CLKS_PER_BIT.
